// File: rtl/calc_cmd_sequencer.sv
// Keypad-to-core command sequencer: buffers key codes in a small FIFO and hands
// them to the calculator core one at a time using its ready/busy/error status.
module calc_cmd_sequencer #(
    parameter int         DEPTH       = 4,
    parameter int         ACK_TIMEOUT = 64,
    parameter logic [3:0] IDLE_CODE   = 4'hD
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       key_valid,
    input  logic [3:0]                 key_code,
    output logic                       key_ready,
    output logic [3:0]                 cmd,
    input  logic [1:0]                 core_status,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [7:0]                 drop_cnt,
    output logic                       busy,
    output logic                       fault
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] NOP_KEY = 4'hD;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_FAULT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [3:0]    fifo_mem [DEPTH];

    logic full, push, drop, pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign key_ready = !full && (state_q != S_FAULT);
    assign push      = key_valid && key_ready && (key_code != NOP_KEY);
    assign drop      = key_valid && !key_ready && (key_code != NOP_KEY);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= key_code;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (core_status == 2'b00) begin
                    state_d = S_FAULT;
                end else if (count_q != '0 && core_status == 2'b10) begin
                    state_d = S_ISSUE;
                    cmd_d   = fifo_mem[rd_ptr_q];
                    tmo_d   = 8'd0;
                end
            end
            S_ISSUE: begin
                if (core_status == 2'b00) begin
                    state_d = S_FAULT;
                end else if (core_status == 2'b01) begin
                    pop     = 1'b1;
                    cmd_d   = IDLE_CODE;
                    state_d = S_WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    // Fault on the edge the count reaches the limit, so cmd is held exactly ACK_TIMEOUT cycles.
                    if ({1'b0, tmo_q} + 9'd1 == 9'(ACK_TIMEOUT)) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (core_status == 2'b10) begin
                    state_d = S_IDLE;
                end else if (core_status == 2'b00) begin
                    state_d = S_FAULT;
                end
            end
            default: ;
        endcase
        if (state_d == S_FAULT) begin
            cmd_d = IDLE_CODE;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        // Entering or sitting in FAULT flushes the queue, overriding any same-edge push.
        if (state_d == S_FAULT) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= IDLE_CODE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 8'd0;
            tmo_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
            tmo_q    <= tmo_d;
        end
    end

    assign cmd        = cmd_q;
    assign fifo_count = count_q;
    assign drop_cnt   = drop_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: directed scenarios plus random traffic, every cycle
// compared against a queue-based behavioural model of the sequencer.
module tb_calc_cmd_sequencer;
    localparam int         DEPTH = 4;
    localparam int         ACK   = 64;
    localparam logic [3:0] IDLE  = 4'hD;
    localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_FAULT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] cmd;
    logic [1:0] core_status;
    logic [2:0] fifo_count;
    logic [7:0] drop_cnt;
    logic       busy;
    logic       fault;

    calc_cmd_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK), .IDLE_CODE(IDLE)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .cmd(cmd), .core_status(core_status),
        .fifo_count(fifo_count), .drop_cnt(drop_cnt), .busy(busy), .fault(fault)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [3:0] mq[$];
    int         m_mode;
    logic [3:0] m_cmd;
    int         m_tmo;
    int         m_drop;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = M_IDLE;
        m_cmd  = IDLE;
        m_tmo  = 0;
        m_drop = 0;
    endtask

    task automatic model_step();
        bit ready, push;
        ready = (mq.size() < DEPTH) && (m_mode != M_FAULT);
        push  = key_valid && ready && (key_code != 4'hD);
        if (key_valid && !ready && key_code != 4'hD && m_drop < 255) m_drop++;
        case (m_mode)
            M_IDLE: begin
                if (core_status == 2'b00) m_mode = M_FAULT;
                else if (mq.size() > 0 && core_status == 2'b10) begin
                    m_mode = M_ISSUE; m_cmd = mq[0]; m_tmo = 0;
                end
            end
            M_ISSUE: begin
                if (core_status == 2'b00) m_mode = M_FAULT;
                else if (core_status == 2'b01) begin
                    void'(mq.pop_front()); m_cmd = IDLE; m_mode = M_WAIT;
                end else begin
                    m_tmo++;
                    if (m_tmo == ACK) m_mode = M_FAULT;
                end
            end
            M_WAIT: begin
                if (core_status == 2'b10) m_mode = M_IDLE;
                else if (core_status == 2'b00) m_mode = M_FAULT;
            end
            default: ;
        endcase
        if (push) mq.push_back(key_code);
        if (m_mode == M_FAULT) begin
            mq.delete();
            m_cmd = IDLE;
        end
    endtask

    task automatic compare_all();
        check("key_ready", key_ready, (mq.size() < DEPTH) && (m_mode != M_FAULT));
        check("cmd", cmd, m_cmd);
        check("fifo_count", fifo_count, mq.size());
        check("drop_cnt", drop_cnt, m_drop);
        check("busy", busy, (m_mode != M_IDLE) || (mq.size() != 0));
        check("fault", fault, m_mode == M_FAULT);
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; core_status = 2'b10;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        compare_all();
    endtask

    initial begin
        logic [3:0] keys1 [4];
        logic [3:0] exp1 [8];
        logic [3:0] log1[$];
        logic [3:0] last;
        int busy_left;

        keys1 = '{4'h3, 4'hA, 4'h5, 4'hE};
        exp1  = '{4'h3, 4'hD, 4'hA, 4'hD, 4'h5, 4'hD, 4'hE, 4'hD};

        // In-order issue with a polite core: ready, busy for 2 cycles, ready
        do_reset();
        busy_left = 0;
        last = cmd;
        for (int i = 0; i < 30; i++) begin
            key_valid = (i < 4);
            key_code  = (i < 4) ? keys1[i] : 4'h0;
            if (busy_left > 0) begin core_status = 2'b01; busy_left--; end
            else if (m_cmd != IDLE) begin core_status = 2'b01; busy_left = 1; end
            else core_status = 2'b10;
            tick();
            if (cmd != last) begin log1.push_back(cmd); last = cmd; end
        end
        check("seq_len", log1.size(), 8);
        for (int i = 0; i < 8; i++)
            check("seq_code", (i < log1.size()) ? int'(log1[i]) : -1, exp1[i]);
        check("seq_empty", fifo_count, 0);

        // Overfill while the core is busy
        do_reset();
        core_status = 2'b01;
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1; key_code = 4'(i + 1);
            tick();
        end
        key_valid = 1'b0;
        check("full_ready", key_ready, 0);
        check("full_drop", drop_cnt, 2);
        check("full_count", fifo_count, 4);
        check("full_cmd", cmd, 4'hD);

        // Pop and push on the same edge while full
        core_status = 2'b10; tick();
        check("issue_head", cmd, 4'h1);
        core_status = 2'b01; key_valid = 1'b1; key_code = 4'h8; tick();
        check("popfull_count", fifo_count, 3);
        check("popfull_drop", drop_cnt, 3);
        key_code = 4'h9; tick();
        check("refill_count", fifo_count, 4);
        key_valid = 1'b0;

        // Handshake timeout: core never leaves ready
        core_status = 2'b10;
        tick(); tick();
        check("tmo_issue", cmd, 4'h2);
        for (int i = 0; i < ACK - 1; i++) tick();
        check("tmo_pre_fault", fault, 0);
        tick();
        check("tmo_fault", fault, 1);
        check("tmo_cmd", cmd, 4'hD);
        check("tmo_count", fifo_count, 0);
        check("tmo_ready", key_ready, 0);

        // Core error during WAIT_DONE, then drops while faulted up to saturation
        do_reset();
        core_status = 2'b01;
        for (int i = 0; i < 3; i++) begin key_valid = 1'b1; key_code = 4'(i + 4); tick(); end
        key_valid = 1'b0;
        core_status = 2'b10; tick();
        core_status = 2'b01; tick();
        check("err_queued", fifo_count, 2);
        core_status = 2'b00; tick();
        check("err_fault", fault, 1);
        check("err_flush", fifo_count, 0);
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1; key_code = 4'h2; tick();
            key_valid = 1'b0; tick();
        end
        check("err_drops", drop_cnt, 3);
        key_valid = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        key_valid = 1'b0;
        check("drop_sat", drop_cnt, 255);

        // Asynchronous reset mid-ISSUE
        do_reset();
        core_status = 2'b01; key_valid = 1'b1; key_code = 4'h7; tick();
        key_valid = 1'b0; core_status = 2'b10; tick();
        check("rst_pre_cmd", cmd, 4'h7);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_cmd", cmd, 4'hD);
        check("rst_count", fifo_count, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_ready", key_ready, 1);
        #2 reset = 1'b0;
        core_status = 2'b01; key_valid = 1'b1; key_code = 4'h9; tick();
        key_valid = 1'b0; core_status = 2'b10; tick();
        check("rst_resume", cmd, 4'h9);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int r;
            if ($urandom_range(0, 199) == 0) do_reset();
            key_valid = ($urandom_range(0, 99) < 60);
            key_code  = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 999);
            if (r < 3)        core_status = 2'b00;
            else if (r < 500) core_status = 2'b10;
            else if (r < 900) core_status = 2'b01;
            else              core_status = 2'b11;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/calc_cmd_sequencer.md
# calc_cmd_sequencer

Command sequencer sitting between the keypad decoder and the calculator core. It buffers key codes in a small FIFO and presents them to the core's `cmd` input one at a time. Each code is handed over using the core's 2-bit `status` as the handshake: `2'b10` ready, `2'b01` busy, `2'b00` error. It also detects core error and handshake stalls, then latches a fault until reset.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, range 2..16.
- `ACK_TIMEOUT`, 64: max cycles in ISSUE waiting for core to leave ready; range 2..255.
- `IDLE_CODE`, 4'hD: no-op code driven on `cmd` when no command is being issued; ignored by the core.

Ports:
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `key_valid` in 1: key code present this cycle.
- `key_code` in 4: 0-9 digit, A add, B sub, C mul, E equals, F backspace.
- `key_ready` out 1: FIFO can accept; equals `!full && !fault`, combinational from registered state.
- `cmd` out 4: registered command to core.
- `core_status` in 2: core status.
- `fifo_count` out $clog2(DEPTH)+1: entries held.
- `drop_cnt` out 8: keys lost while full or faulted; saturates at 255.
- `busy` out 1: `state != IDLE || fifo_count != 0`.
- `fault` out 1: latched error.

## Operation
- FIFO push:
  - A push occurs when `key_valid && key_ready`.
  - `key_valid && !key_ready` increments `drop_cnt` (saturating); the FIFO is unchanged.
  - Code 4'hD is never stored; it is silently discarded and not counted.
- States IDLE, ISSUE, WAIT_DONE, FAULT:
  - IDLE:
    - `cmd = IDLE_CODE`.
    - If `fifo_count != 0 && core_status == 2'b10`, go to ISSUE and load `cmd` with the FIFO head.
    - `core_status == 2'b00` sends the block to FAULT.
  - ISSUE:
    - `cmd` holds the head code and the timeout counter increments.
    - `core_status == 2'b01`: pop the head, set `cmd = IDLE_CODE`, go to WAIT_DONE.
    - `2'b00`: go to FAULT.
    - Counter reaching `ACK_TIMEOUT`: go to FAULT.
    - `2'b10` or `2'b11`: stay.
  - WAIT_DONE:
    - `2'b10`: go to IDLE.
    - `2'b00`: go to FAULT.
    - Otherwise stay, with no timeout, because multiply is long.
  - FAULT:
    - `fault = 1` and the FIFO is flushed (`fifo_count = 0`).
    - `cmd = IDLE_CODE` and `key_ready = 0`.
    - The block stays in FAULT until reset.
- Order is strict FIFO; each code is issued exactly once and never re-issued after the pop.
- Simultaneous push and pop in the same cycle: both take effect and `fifo_count` is unchanged.
  - When full, `key_ready` is already 0, so a push in the pop cycle is dropped.
  - The freed slot is usable from the next cycle.
- Pointers wrap modulo DEPTH; full is `fifo_count == DEPTH` and empty is `fifo_count == 0`.

## Timing
- Reset values:
  - `cmd = IDLE_CODE`, `key_ready = 1`.
  - `fifo_count = 0`, `drop_cnt = 0`.
  - `busy = 0`, `fault = 0`, state IDLE, timeout counter 0.
- A reset asserted mid-handshake returns to these values immediately (asynchronously); the in-flight code is lost.
- Push at edge N: `fifo_count` updates after N. The entry is eligible for issue at edge N+1.
- Best-case key-to-`cmd` latency is 2 edges: push at N, state ISSUE with `cmd` = code after N+1.
- Pop and `cmd` return to `IDLE_CODE` happen on the same edge that samples busy in ISSUE.
- The timeout counter clears on entry to ISSUE. FAULT is entered on the edge where the count equals `ACK_TIMEOUT`, i.e. `cmd` is held for exactly `ACK_TIMEOUT` cycles.
- `fault` rises on the edge following the `core_status == 2'b00` sample.

## Test plan
- Reset, then push codes 3, A, 5, E with `core_status` toggling 10→01 (2 cycles)→10 per command. Required: `cmd` shows 3, D, A, D, 5, D, E, D in order, each code held until busy is sampled, and `fifo_count` returns to 0.
- Push 6 keys back-to-back with DEPTH=4 while `core_status` stays 01. Required: `key_ready` falls after the 4th push, `drop_cnt = 2`, `fifo_count = 4`, and `cmd` stays at D.
- Hold `core_status = 10` after an issue. Required: after 64 cycles in ISSUE, `fault = 1`, `cmd = D`, `fifo_count = 0`, `key_ready = 0`.
- Drive `core_status = 00` during WAIT_DONE with 2 entries queued. Required: next edge `fault = 1` and the FIFO is flushed; later `key_valid` pulses increment `drop_cnt`.
- When full, pop and `key_valid` occur on the same edge. Required: the push is dropped, `drop_cnt` increments, and `fifo_count` becomes 3; a push on the next cycle is accepted and `fifo_count` returns to 4.
- Assert `reset` mid-ISSUE with `cmd = 7`. Required: `cmd = D` and all counters 0 without waiting for a clock edge; normal issue resumes after release.
